pe_ctrl_seq: RTL



---
 rtl/pe_ctrl_seq_if.sv | 20 ++
 rtl/pe_ctrl_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_ctrl_seq_if.sv
// Instruction channel between the instruction source and the PE control sequencer.
interface pe_ctrl_seq_if #(
  parameter int INST_WIDTH = 64
);
  logic                  inst_v;
  logic                  inst_rdy;
  logic [INST_WIDTH-1:0] inst;

  modport master (
    output inst_v,
    output inst,
    input  inst_rdy
  );

  modport slave (
    input  inst_v,
    input  inst,
    output inst_rdy
  );
endinterface

// File: rtl/pe_ctrl_seq.sv
// PE-array control sequencer: decodes instructions into per-lane DSP48 controls, repeats, delays write-back.
// Per-lane masking from the instruction mask field is enabled by defining PE_CTRL_LANE_MASK_EN.
module pe_ctrl_seq #(
  parameter int LANES      = 4,
  parameter int WB_DELAY   = 5,
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  pe_ctrl_seq_if.slave            inst_if,
  input  logic [2*DATA_WIDTH-1:0] din_ld_i,
  input  logic [2*DATA_WIDTH-1:0] din_wb_i,
  output logic                    dout_v_o,
  output logic [2*DATA_WIDTH-1:0] dout_o,
  output logic [4*LANES-1:0]      alumode_o,
  output logic [5*LANES-1:0]      inmode_o,
  output logic [7*LANES-1:0]      opmode_o,
  output logic [LANES-1:0]        cea2_o,
  output logic [LANES-1:0]        ceb2_o,
  output logic [LANES-1:0]        usemult_o,
  output logic                    busy_o
);

  // state   | meaning
  // S_IDLE  | ready; an accepted instruction is issued once on the accept edge
  // S_ISSUE | re-issuing the latched instruction, cnt counts remaining repeats
  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  typedef struct packed {
    logic [3:0] alu;
    logic [4:0] inm;
    logic [6:0] opm;
    logic       cea;
    logic       ceb;
    logic       um;
  } dsp_ctrl_t;

  localparam int WB_BIT  = 63;
  localparam int OP_LSB  = 24;
  localparam int REP_LSB = 16;

  function automatic dsp_ctrl_t decode(input logic [2:0] op);
    dsp_ctrl_t c;
    c = '0;
    // op[2] only distinguishes immediate variants; DSP setup is identical
    case (op[1:0])
      2'b01: begin
        c.opm = 7'b0110011;
        c.cea = 1'b1;
        c.ceb = 1'b1;
      end
      2'b10: begin
        c.alu = 4'b0011;
        c.opm = 7'b0110011;
        c.cea = 1'b1;
        c.ceb = 1'b1;
      end
      2'b11: begin
        c.inm = 5'b10001;
        c.opm = 7'b0000101;
        c.um  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic       wb_q, wb_d;
  logic       issue_d;
  logic       accept;
`ifdef PE_CTRL_LANE_MASK_EN
  logic [LANES-1:0] mask_q, mask_d;
`endif

  logic [LANES-1:0]      lane_en;
  dsp_ctrl_t             enc_d;
  logic [4*LANES-1:0]    alumode_q, alumode_d;
  logic [5*LANES-1:0]    inmode_q, inmode_d;
  logic [7*LANES-1:0]    opmode_q, opmode_d;
  logic [LANES-1:0]      cea2_q, cea2_d;
  logic [LANES-1:0]      ceb2_q, ceb2_d;
  logic [LANES-1:0]      usemult_q, usemult_d;
  logic [WB_DELAY-1:0]   wb_sr_q;
  logic [2*DATA_WIDTH-1:0] dout_q;

  // Only the wb flag, opcode, repeat and mask fields carry meaning
  logic unused_inst;
  assign unused_inst = ^inst_if.inst;

  assign inst_if.inst_rdy = (state_q == S_IDLE) && !rst;
  assign accept           = inst_if.inst_v && inst_if.inst_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    wb_d    = wb_q;
    issue_d = 1'b0;
`ifdef PE_CTRL_LANE_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          issue_d = 1'b1;
          op_d    = inst_if.inst[OP_LSB +: 3];
          wb_d    = inst_if.inst[WB_BIT];
`ifdef PE_CTRL_LANE_MASK_EN
          mask_d  = inst_if.inst[LANES-1:0];
`endif
          if (inst_if.inst[REP_LSB +: 8] != 8'd0) begin
            cnt_d   = inst_if.inst[REP_LSB +: 8];
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        issue_d = 1'b1;
        cnt_d   = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef PE_CTRL_LANE_MASK_EN
    lane_en = issue_d ? mask_d : '0;
`else
    lane_en = issue_d ? {LANES{1'b1}} : '0;
`endif
  end

  assign enc_d = decode(op_d);

  always_comb begin
    alumode_d = '0;
    inmode_d  = '0;
    opmode_d  = '0;
    cea2_d    = '0;
    ceb2_d    = '0;
    usemult_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_en[l]) begin
        alumode_d[4*l +: 4] = enc_d.alu;
        inmode_d[5*l +: 5]  = enc_d.inm;
        opmode_d[7*l +: 7]  = enc_d.opm;
        cea2_d[l]           = enc_d.cea;
        ceb2_d[l]           = enc_d.ceb;
        usemult_d[l]        = enc_d.um;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      wb_q      <= 1'b0;
`ifdef PE_CTRL_LANE_MASK_EN
      mask_q    <= '0;
`endif
      alumode_q <= '0;
      inmode_q  <= '0;
      opmode_q  <= '0;
      cea2_q    <= '0;
      ceb2_q    <= '0;
      usemult_q <= '0;
      wb_sr_q   <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      wb_q      <= wb_d;
`ifdef PE_CTRL_LANE_MASK_EN
      mask_q    <= mask_d;
`endif
      alumode_q <= alumode_d;
      inmode_q  <= inmode_d;
      opmode_q  <= opmode_d;
      cea2_q    <= cea2_d;
      ceb2_q    <= ceb2_d;
      usemult_q <= usemult_d;
      // tap 0 lines up with the issue's control cycle
      wb_sr_q   <= {wb_sr_q[WB_DELAY-2:0], issue_d & wb_d};
      dout_q    <= wb_sr_q[WB_DELAY-1] ? din_wb_i : din_ld_i;
    end
  end

  assign alumode_o = alumode_q;
  assign inmode_o  = inmode_q;
  assign opmode_o  = opmode_q;
  assign cea2_o    = cea2_q;
  assign ceb2_o    = ceb2_q;
  assign usemult_o = usemult_q;
  assign dout_v_o  = wb_sr_q[WB_DELAY-1];
  assign dout_o    = dout_q;
  assign busy_o    = (state_q == S_ISSUE);

endmodule
